// File: rtl/cam_pkg.sv
// Shared opcode constants, command/state enums and beat helpers
// for the CAM command generator.
package cam_pkg;

    localparam int OP_W = 32;
    localparam int BEAT_W = 512;

    localparam logic [OP_W-1:0] OP_IDLE       = 32'hffff_ff00;
    localparam logic [OP_W-1:0] OP_UPDATE_ALL = 32'hffff_ff01;
    localparam logic [OP_W-1:0] OP_UPDATE_ONE = 32'hffff_ff02;
    localparam logic [OP_W-1:0] OP_SEARCH     = 32'hffff_ff03;

    typedef enum logic [1:0] {
        CMD_UPDATE_ALL = 2'd0,
        CMD_SEARCH     = 2'd1,
        CMD_UPDATE_ONE = 2'd2,
        CMD_ILLEGAL    = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_WAIT_END
    } gen_state_e;

    function automatic logic [OP_W-1:0] op_code(cmd_op_e op);
        logic [OP_W-1:0] code;
        unique case (op)
            CMD_UPDATE_ALL: code = OP_UPDATE_ALL;
            CMD_SEARCH:     code = OP_SEARCH;
            CMD_UPDATE_ONE: code = OP_UPDATE_ONE;
            default:        code = OP_IDLE;
        endcase
        return code;
    endfunction

    function automatic logic [OP_W-1:0] op_field(logic [BEAT_W-1:0] beat);
        return beat[BEAT_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/cam_beat_reg.sv
// Single output register stage; holds data and valid until the
// downstream handshake, refills in the same cycle it drains.
module cam_beat_reg #(
    parameter int W = 512
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/krnl_cam_rtl_cmd_gen.sv
// Turns host command requests into CAM opcode beats and keeps at most
// one command in flight until the CAM signals completion.
module krnl_cam_rtl_cmd_gen
    import cam_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 512,
    parameter int OP_CODE_WIDTH = 32,
    parameter int LEN_WIDTH     = 16,
    parameter int TIMEOUT_CYC   = 4096
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [C_DATA_WIDTH-OP_CODE_WIDTH-1:0] cmd_payload,
    input  logic [LEN_WIDTH-1:0]              cmd_len,
    input  logic [C_DATA_WIDTH-1:0]           s_body_data,
    input  logic                              s_body_valid,
    output logic                              s_body_ready,
    output logic [C_DATA_WIDTH-1:0]           m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    input  logic                              search_end,
    input  logic                              update_all_end,
    output logic                              busy,
    output logic                              err_timeout,
    output logic [31:0]                       cmd_count
);

    localparam int PW = C_DATA_WIDTH - OP_CODE_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    gen_state_e           state_q, state_d;
    cmd_op_e              op_q, op_d;
    logic [PW-1:0]        pay_q, pay_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] ld_q, ld_d;
    logic [LEN_WIDTH-1:0] acc_q, acc_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 arm_q, arm_d;
    logic                 end_seen_q, end_seen_d;
    logic                 err_q, err_d;
    logic                 rdy_q, rdy_d;
    logic [31:0]          cnt_q, cnt_d;

    logic                    bin_valid;
    logic                    bin_ready;
    logic [C_DATA_WIDTH-1:0] bin_data;
    logic                    end_match;
    logic                    m_hs;
    logic [OP_CODE_WIDTH-1:0] hdr_op;

    assign cmd_ready   = rdy_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = err_q;
    assign cmd_count   = cnt_q;
    assign m_hs        = m_valid && m_ready;
    assign end_match   = (op_q == CMD_UPDATE_ALL) ? update_all_end : search_end;
    assign hdr_op      = OP_CODE_WIDTH'(op_code(cmd_op_e'(cmd_op)));

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        pay_d        = pay_q;
        len_d        = len_q;
        ld_d         = ld_q;
        acc_d        = acc_q;
        tmo_d        = tmo_q;
        arm_d        = arm_q;
        end_seen_d   = end_seen_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        bin_valid    = 1'b0;
        bin_data     = s_body_data;
        s_body_ready = 1'b0;

        // The end pulse may land before WAIT_END (e.g. during BODY).
        if (arm_q && end_match) end_seen_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && rdy_q) begin
                    op_d  = cmd_op_e'(cmd_op);
                    pay_d = cmd_payload;
                    len_d = cmd_len;
                    ld_d  = '0;
                    acc_d = '0;
                    tmo_d = '0;
                    if (cmd_op_e'(cmd_op) != CMD_ILLEGAL) begin
                        bin_valid = 1'b1;
                        bin_data  = {hdr_op, cmd_payload};
                        state_d   = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (m_hs) begin
                    arm_d = 1'b1;
                    if (op_q == CMD_UPDATE_ALL && len_q != '0) state_d = ST_BODY;
                    else state_d = ST_WAIT_END;
                end
            end
            ST_BODY: begin
                if (ld_q != len_q) begin
                    s_body_ready = bin_ready;
                    bin_valid    = s_body_valid;
                    if (s_body_valid && bin_ready) ld_d = ld_q + LEN_WIDTH'(1);
                end
                if (m_hs) begin
                    acc_d = acc_q + LEN_WIDTH'(1);
                    if (acc_d == len_q) state_d = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                if (end_seen_q || end_match) begin
                    state_d    = ST_IDLE;
                    cnt_d      = cnt_q + 32'd1;
                    arm_d      = 1'b0;
                    end_seen_d = 1'b0;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    arm_d      = 1'b0;
                    end_seen_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= CMD_UPDATE_ALL;
            pay_q      <= '0;
            len_q      <= '0;
            ld_q       <= '0;
            acc_q      <= '0;
            tmo_q      <= '0;
            arm_q      <= 1'b0;
            end_seen_q <= 1'b0;
            err_q      <= 1'b0;
            rdy_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            pay_q      <= pay_d;
            len_q      <= len_d;
            ld_q       <= ld_d;
            acc_q      <= acc_d;
            tmo_q      <= tmo_d;
            arm_q      <= arm_d;
            end_seen_q <= end_seen_d;
            err_q      <= err_d;
            rdy_q      <= rdy_d;
            cnt_q      <= cnt_d;
        end
    end

    cam_beat_reg #(
        .W(C_DATA_WIDTH)
    ) u_beat (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bin_valid),
        .in_ready (bin_ready),
        .in_data  (bin_data),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .out_data (m_data)
    );

endmodule
